muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width (legal: even, >=8).
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH)+1, meaning iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  WIDTH  rs operand (multiplicand / dividend).
REQ-008 b  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 hi_we  input  1  MTHI write strobe.
REQ-010 lo_we  input  1  MTLO write strobe.
REQ-011 wdata  input  WIDTH  MTHI/MTLO data.
REQ-012 busy  output  1  high while not IDLE.
REQ-013 done  output  1  one-cycle pulse: HI/LO hold new result.
REQ-014 div0  output  1  sticky per-operation flag: last DIV/DIVU had b==0.
REQ-015 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-016 lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-017 FSM states SHALL be IDLE, RUN, FIX, DONE; busy=1 in RUN, FIX; busy=0 in IDLE, DONE.
REQ-018 IDLE & start: operands latched; signed ops store magnitudes plus sign bits; counter=WIDTH; next state RUN (or DONE per REQ-024).
REQ-019 RUN: one bit per cycle -- multiply: shift-add on 2*WIDTH accumulator; divide: restoring shift-subtract on WIDTH remainder; counter decrements; exit to FIX when counter reaches 0, i.e. exactly WIDTH cycles in RUN.
REQ-020 FIX: one cycle; two's-complement sign correction; result written to HI/LO at FIX->DONE edge; next state DONE.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE; start in DONE ignored.
REQ-022 Latency: start sampled at edge E -> done high in cycle after edge E+WIDTH+1 (WIDTH+2 edges total); next start accepted the cycle after done.
REQ-023 Multiply: HI:LO = full 2*WIDTH product; MULT signed x signed, MULTU unsigned x unsigned; no overflow flag.
REQ-024 Divide by zero (b==0, DIV or DIVU): skip RUN/FIX; IDLE->DONE directly; LO=all ones, HI=a; div0=1; done one cycle after start edge.
REQ-025 Signed divide: quotient truncates toward zero; remainder takes sign of dividend (a).
REQ-026 DIV overflow (a=most-negative, b=all ones): LO=most-negative, HI=0, div0=0, normal latency.
REQ-027 div0 SHALL clear on every accepted start with b!=0 or op MULT/MULTU.
REQ-028 start while busy SHALL be ignored; no queueing.
REQ-029 hi_we/lo_we SHALL take effect at next edge only in IDLE or DONE; ignored while busy.
REQ-030 start and hi_we/lo_we in same IDLE cycle: start accepted, write dropped.
REQ-031 hi_we/lo_we in DONE: register write overrides result of that register at the following edge (result already visible in DONE cycle).
REQ-032 op and operands SHALL be ignored except on the accepting edge; changes during RUN have no effect.
REQ-033 hi/lo SHALL hold value between updates; never change in RUN or FIX.

Reset
REQ-034 rst_n=0 SHALL force immediately, independent of clk: state IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter and datapath cleared.
REQ-035 Reset mid-operation SHALL abort; no done pulse; HI/LO remain 0 after release.
REQ-036 First start accepted on first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-037 MULT a=FFFFFFFD (-3), b=00000005 -> done 34 edges after start; hi=FFFFFFFF, lo=FFFFFFF1.
REQ-038 DIVU a=100, b=7 -> lo=0000000E, hi=00000002; DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-039 DIV a=12345678, b=0 -> done 1 edge after start; div0=1; lo=FFFFFFFF, hi=12345678; following MULTU 2x3 -> div0=0, lo=6, hi=0.
REQ-040 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div0=0, latency 34 edges.
REQ-041 Start MULTU, pulse start and hi_we during RUN, assert rst_n=0 at RUN cycle 10 -> no second operation, no HI write, no done; busy=0, hi=lo=0 immediately.
REQ-042 IDLE: hi_we=1, wdata=CAFEF00D -> hi=CAFEF00D next cycle; same cycle with start=1 -> hi unchanged by write, operation runs.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide: one bit per cycle, WIDTH+2 cycles start-to-done (1 for divide-by-zero).
// No backpressure: start is taken only in IDLE, and busy marks when it would be dropped.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t               state_q;
   logic [CNTW-1:0]      cnt_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opb_q;
   logic                 is_div_q, neg_res_q, neg_rem_q;
   logic                 busy_q, done_q, div0_q;
   logic [WIDTH-1:0]     hi_q, lo_q;

   logic                 neg_a, neg_b, is_div_in, b_zero;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     res_hi, res_lo;

   // op[0]=0 selects the signed variant; the datapath works on magnitudes only
   assign is_div_in = op[1];
   assign neg_a     = ~op[0] & a[WIDTH-1];
   assign neg_b     = ~op[0] & b[WIDTH-1];
   assign mag_a     = neg_a ? -a : a;
   assign mag_b     = neg_b ? -b : b;
   assign b_zero    = (b == '0);

   // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_sh - {1'b0, opb_q};
      if (is_div_q)
         acc_d = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      prod = neg_res_q ? -acc_q : acc_q;
      if (is_div_q) begin
         res_lo = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         res_hi = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      end else begin
         res_lo = prod[WIDTH-1:0];
         res_hi = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  div0_q    <= is_div_in & b_zero;
                  cnt_q     <= CNTW'(WIDTH);
                  is_div_q  <= is_div_in;
                  neg_res_q <= neg_a ^ neg_b;
                  neg_rem_q <= neg_a;
                  opb_q     <= mag_b;
                  acc_q     <= {{WIDTH{1'b0}}, mag_a};
                  if (is_div_in && b_zero) begin
                     hi_q    <= a;
                     lo_q    <= '1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= RUN;
                  end
               end else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - CNTW'(1);
               if (cnt_q == CNTW'(1)) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= res_hi;
               lo_q    <= res_lo;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised scoreboard bench for muldiv_unit: driver queues expected HI/LO/div0/latency,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0, b = '0, wdata = '0;
   logic          hi_we = 1'b0, lo_we = 1'b0;
   logic          busy, done, div0;
   logic [W-1:0]  hi, lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int unsigned  se;
   } exp_t;

   exp_t         exp_q[$];
   int           tests = 0;
   int           fails = 0;
   int unsigned  cyc = 0;
   logic [W-1:0] prev_hi = '0, prev_lo = '0;
   bit           moved = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Reference: plain arithmetic on 64-bit integers
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      longint          sx, sy, sq, sr;
      longint unsigned ux, uy, up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      e.dz = 1'b0;
      e.se = 0;
      e.hi = '0;
      e.lo = '0;
      if (o == 2'd0) begin
         sq = sx * sy;
         e.hi = sq[63:32];
         e.lo = sq[31:0];
      end else if (o == 2'd1) begin
         up = ux * uy;
         e.hi = up[63:32];
         e.lo = up[31:0];
      end else if (y == '0) begin
         e.hi = x;
         e.lo = '1;
         e.dz = 1'b1;
      end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         e.hi = '0;
         e.lo = 32'h8000_0000;
      end else if (o == 2'd2) begin
         sq = sx / sy;
         sr = sx % sy;
         e.lo = sq[31:0];
         e.hi = sr[31:0];
      end else begin
         e.lo = x / y;
         e.hi = x % y;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (busy && (hi !== prev_hi || lo !== prev_lo)) moved = 1'b1;
      prev_hi = hi;
      prev_lo = lo;
      if (rst_n && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("div0", 64'(div0), 64'(e.dz));
            chk("latency", 64'(cyc - e.se), e.dz ? 64'(0) : 64'(W + 1));
            chk("busy_in_done", 64'(busy), 64'(0));
            chk("hilo_stable_while_busy", 64'(moved), 64'(0));
            moved = 1'b0;
         end
      end
   end

   task automatic clear_inputs();
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || done) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", {62'b0, busy, done}, 64'(0));
   endtask

   // Issue one op; optionally drive garbage on every input while busy. Returns in the DONE cycle.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit junk);
      exp_t e;
      int   n = 0;
      wait_idle();
      e = model(o, x, y);
      e.se = cyc + 1;
      exp_q.push_back(e);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(negedge clk);
      clear_inputs();
      while (busy && n < 100) begin
         if (junk) begin
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            a     = $urandom;
            b     = $urandom;
            hi_we = 1'($urandom_range(0, 1));
            lo_we = 1'($urandom_range(0, 1));
            wdata = $urandom;
         end
         @(negedge clk);
         n++;
      end
      clear_inputs();
      chk("done_seen", 64'(done), 64'(1));
   endtask

   function automatic logic [W-1:0] rnd_opnd();
      logic [W-1:0] edges [5];
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 5))
         0:       return edges[$urandom_range(0, 4)];
         1:       return W'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      #3;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_div0", 64'(div0), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First start immediately after reset release; latency checked by the monitor
      issue(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
      issue(2'd3, 32'd100, 32'd7, 1'b0);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      issue(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
      issue(2'd2, 32'h1234_5678, 32'h0, 1'b0);
      issue(2'd1, 32'd2, 32'd3, 1'b0);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(2'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      // MTHI/MTLO in IDLE
      wait_idle();
      hi_we = 1'b1;
      wdata = 32'hCAFE_F00D;
      @(negedge clk);
      clear_inputs();
      chk("mthi_idle", 64'(hi), 64'h0000_0000_CAFE_F00D);
      lo_we = 1'b1;
      wdata = 32'h0BAD_F00D;
      @(negedge clk);
      clear_inputs();
      chk("mtlo_idle", 64'(lo), 64'h0000_0000_0BAD_F00D);
      chk("mtlo_keeps_hi", 64'(hi), 64'h0000_0000_CAFE_F00D);

      // Write in the same cycle as start is dropped; a leak shows as HI moving while busy
      hi_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      issue(2'd1, 32'd3, 32'd4, 1'b0);

      // Write during DONE overrides the freshly posted result
      issue(2'd1, 32'd6, 32'd7, 1'b0);
      lo_we = 1'b1;
      wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      clear_inputs();
      chk("mtlo_done_override", 64'(lo), 64'h0000_0000_A5A5_A5A5);
      chk("mtlo_done_keeps_hi", 64'(hi), 64'(0));

      for (int i = 0; i < 250; i++) begin
         logic [W-1:0] x, y;
         x = rnd_opnd();
         y = rnd_opnd();
         issue(2'($urandom_range(0, 3)), x, y, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of RUN with junk start/hi_we being driven
      wait_idle();
      e = model(2'd1, 32'h1111_1111, 32'h2222_2222);
      e.se = cyc + 1;
      exp_q.push_back(e);
      start = 1'b1;
      op = 2'd1;
      a = 32'h1111_1111;
      b = 32'h2222_2222;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         start = 1'b1;
         hi_we = 1'b1;
         wdata = $urandom;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk("abort_hi", 64'(hi), 64'(0));
      chk("abort_lo", 64'(lo), 64'(0));
      clear_inputs();
      void'(exp_q.pop_back());
      moved = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_abort_busy", 64'(busy), 64'(0));
      chk("post_abort_hi", 64'(hi), 64'(0));
      chk("post_abort_lo", 64'(lo), 64'(0));

      // Short reset pulse then an immediate start
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(2'd2, 32'hFFFF_FF9C, 32'd10, 1'b0);
      wait_idle();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
